// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle control unit and the MIPS datapath.
// Latency: pure wiring, no storage.
// Backpressure: none; halt is the only throttle and it acts at instruction boundaries.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             halt;
    logic             IRWr;
    logic             PCWr;
    logic             RegWr;
    logic             ExtOp;
    logic [2:0]       ALUctr;
    logic             ALUsrc;
    logic             MemWr;
    logic             RegDst;
    logic             MemtoReg;
    logic             branch;
    logic             jump;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    // Control unit side: consumes IR fields and halt, drives every strobe.
    modport master (
        input  op, func, halt,
        output IRWr, PCWr, RegWr, ExtOp, ALUctr, ALUsrc, MemWr,
               RegDst, MemtoReg, branch, jump, illegal, instret
    );

    // Datapath side: exports IR fields and halt, consumes every strobe.
    modport slave (
        output op, func, halt,
        input  IRWr, PCWr, RegWr, ExtOp, ALUctr, ALUsrc, MemWr,
               RegDst, MemtoReg, branch, jump, illegal, instret
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with retired-instruction counter; MC_CTRL_TRAP_EN enables TRAP on illegal ops.
// Latency: 4 cycles j/beq, 5 sw/R-type/ori/addiu, 6 lw, IDLE to IDLE; strobes are Moore outputs of the registered state.
// Backpressure: halt is sampled only in IDLE and holds the FSM there; an instruction in flight always completes.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_control_if.master  bus
);
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUBU = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, func_q;
    logic [CNT_W-1:0] instret_q;
    logic             in_legal;
    logic [2:0]       alu_ctr;
    logic             alu_src, ext_op;
    logic             irwr, pcwr, regwr, extop, alusrc, memwr, regdst, memtoreg, br, jp;
    logic [2:0]       aluctr;

    // Legality check on the live IR fields, used for the ID-state decision.
    always_comb begin
        in_legal = 1'b0;
        case (bus.op)
            OP_R: begin
                case (bus.func)
                    6'b100001, 6'b100000, 6'b100011,
                    6'b100010, 6'b101011, 6'b101010: in_legal = 1'b1;
                    default:                         in_legal = 1'b0;
                endcase
            end
            OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: in_legal = 1'b1;
            default: in_legal = 1'b0;
        endcase
    end

    // ALU control decode from the fields latched in ID, so EX/MEM/WB stay stable.
    always_comb begin
        alu_ctr = ALU_ADDU;
        alu_src = 1'b0;
        ext_op  = 1'b0;
        case (op_q)
            OP_R: begin
                case (func_q)
                    6'b100000: alu_ctr = ALU_ADD;
                    6'b100011: alu_ctr = ALU_SUBU;
                    6'b100010: alu_ctr = ALU_SUB;
                    6'b101011: alu_ctr = ALU_SLTU;
                    6'b101010: alu_ctr = ALU_SLT;
                    default:   alu_ctr = ALU_ADDU;
                endcase
            end
            OP_ORI:       begin alu_ctr = ALU_OR;   alu_src = 1'b1; end
            OP_ADDIU:     begin alu_ctr = ALU_ADDU; alu_src = 1'b1; ext_op = 1'b1; end
            OP_LW, OP_SW: begin alu_ctr = ALU_ADDU; alu_src = 1'b1; ext_op = 1'b1; end
            OP_BEQ:       alu_ctr = ALU_SUBU;
            default:      alu_ctr = ALU_ADDU;
        endcase
    end

    // State register and decode latch; decode regs capture the IR on the edge leaving ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 6'd0;
            func_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                op_q   <= bus.op;
                func_q <= bus.func;
            end
        end
    end

    // Next-state and Moore strobes; ALU controls stay asserted through MEM/WB so ALUout remains valid.
    always_comb begin
        state_d  = state_q;
        irwr     = 1'b0;
        pcwr     = 1'b0;
        regwr    = 1'b0;
        extop    = 1'b0;
        aluctr   = 3'b000;
        alusrc   = 1'b0;
        memwr    = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        br       = 1'b0;
        jp       = 1'b0;
        case (state_q)
            S_IDLE: if (!bus.halt) state_d = S_IF;
            S_IF: begin
                irwr    = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                if (in_legal) begin
                    state_d = S_EX;
                end else begin
`ifdef MC_CTRL_TRAP_EN
                    state_d = S_TRAP;
`else
                    pcwr    = 1'b1;
                    state_d = S_IDLE;
`endif
                end
            end
            S_EX: begin
                aluctr = alu_ctr;
                alusrc = alu_src;
                extop  = ext_op;
                if (op_q == OP_BEQ) begin
                    br      = 1'b1;
                    pcwr    = 1'b1;
                    state_d = S_IDLE;
                end else if (op_q == OP_J) begin
                    jp      = 1'b1;
                    pcwr    = 1'b1;
                    state_d = S_IDLE;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                aluctr = alu_ctr;
                alusrc = alu_src;
                extop  = ext_op;
                if (op_q == OP_SW) begin
                    memwr   = 1'b1;
                    pcwr    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                aluctr   = alu_ctr;
                alusrc   = alu_src;
                extop    = ext_op;
                regwr    = 1'b1;
                pcwr     = 1'b1;
                regdst   = (op_q == OP_R);
                memtoreg = (op_q == OP_LW);
                state_d  = S_IDLE;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Retired-instruction counter: one count per PCWr pulse, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= '0;
        else if (pcwr) instret_q <= instret_q + CNT_W'(1);
    end

`ifdef MC_CTRL_TRAP_EN
    logic illegal_q;
    // Sticky illegal flag, set on the edge that enters TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else if (state_q == S_ID && !in_legal) illegal_q <= 1'b1;
    end
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.IRWr     = irwr;
    assign bus.PCWr     = pcwr;
    assign bus.RegWr    = regwr;
    assign bus.ExtOp    = extop;
    assign bus.ALUctr   = aluctr;
    assign bus.ALUsrc   = alusrc;
    assign bus.MemWr    = memwr;
    assign bus.RegDst   = regdst;
    assign bus.MemtoReg = memtoreg;
    assign bus.branch   = br;
    assign bus.jump     = jp;
    assign bus.instret  = instret_q;
endmodule
